// File: rtl/regression_pkg.sv
// Shared types and constants for the regression sequencer: FSM states,
// default sizing and the run-length helper.
package regression_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEAN,
    WAIT_MEAN,
    SS,
    CALC_B1,
    CALC_B0,
    ERR,
    DONE
  } state_t;

  localparam int DEFAULT_N_SAMPLES = 150;
  localparam int DEFAULT_ADDR_W    = 8;

  // Three address sweeps per run, plus the start cycle in IDLE, CALC_B1, CALC_B0 and DONE.
  localparam int SWEEPS_PER_RUN   = 3;
  localparam int FIXED_RUN_CYCLES = 4;

  // Pass length in cycles, counting the IDLE cycle that presents start as cycle 1
  // and ending with the Ready cycle.
  function automatic int run_latency(input int n_samples, input int wait_cycles);
    return SWEEPS_PER_RUN * n_samples + wait_cycles + FIXED_RUN_CYCLES;
  endfunction

endpackage

// File: rtl/regression_sequencer_counter.sv
// Sample address counter shared by the MEAN, SS and ERR sweeps; wraps to 0
// after the last sample so the next sweep always starts at address 0.
module sample_addr_counter
  import regression_pkg::*;
#(
  parameter int N_SAMPLES = DEFAULT_N_SAMPLES,
  parameter int ADDR_W    = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  assign last = enable && (count == LAST_ADDR);

  // Wrapping on the terminal count avoids ever needing an N_SAMPLES value in ADDR_W bits.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/regression_sequencer.sv
// Control sequencer for a linear-regression datapath: sweeps the sample
// memory for means, sums of products/squares and error, then pulses Ready.
module regression_sequencer
  import regression_pkg::*;
#(
  parameter int N_SAMPLES = DEFAULT_N_SAMPLES,
  parameter int ADDR_W    = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mean_done,
  output logic [ADDR_W-1:0] adrr,
  output logic              en1,
  output logic              ld_p,
  output logic              ld_ss,
  output logic              ld_B1,
  output logic              ld_B0,
  output logic              en2,
  output logic              ld_er,
  output logic              Ready,
  output logic              busy
);

  state_t state;
  state_t state_next;
  logic   mean_seen;
  logic   mean_seen_next;
  logic   sweep;
  logic   last;

  assign sweep = (state == MEAN) || (state == SS) || (state == ERR);

  sample_addr_counter #(
    .N_SAMPLES(N_SAMPLES),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .clear (!sweep),
    .enable(sweep),
    .count (adrr),
    .last  (last)
  );

  // mean_seen remembers a mean_done pulse that arrives before the MEAN sweep ends.
  always_comb begin
    state_next     = state;
    mean_seen_next = mean_seen;
    case (state)
      IDLE: begin
        if (start) begin
          state_next     = MEAN;
          mean_seen_next = 1'b0;
        end
      end
      MEAN: begin
        if (mean_done) mean_seen_next = 1'b1;
        if (last) state_next = WAIT_MEAN;
      end
      WAIT_MEAN: begin
        if (mean_done) mean_seen_next = 1'b1;
        if (mean_seen || mean_done) state_next = SS;
      end
      SS: begin
        if (last) state_next = CALC_B1;
      end
      CALC_B1: state_next = CALC_B0;
      CALC_B0: state_next = ERR;
      ERR: begin
        if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with adrr.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mean_seen <= 1'b0;
      en1       <= 1'b0;
      ld_p      <= 1'b0;
      ld_ss     <= 1'b0;
      ld_B1     <= 1'b0;
      ld_B0     <= 1'b0;
      en2       <= 1'b0;
      ld_er     <= 1'b0;
      Ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      mean_seen <= mean_seen_next;
      en1       <= (state_next == MEAN);
      ld_p      <= (state_next == SS);
      ld_ss     <= (state_next == SS);
      ld_B1     <= (state_next == CALC_B1);
      ld_B0     <= (state_next == CALC_B0);
      en2       <= (state_next == ERR);
      ld_er     <= (state_next == ERR);
      Ready     <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_regression_sequencer.sv
// Self-checking bench for regression_sequencer: a cycle table for a nominal
// N_SAMPLES=4 run, then directed multi-cycle sequences on N=4, N=1 and N=256.
module tb_regression_sequencer;
  import regression_pkg::*;

  // Output bundle order: {en1, ld_p, ld_ss, ld_B1, ld_B0, en2, ld_er, Ready, busy}
  localparam logic [8:0] O_IDLE = 9'b000000000;
  localparam logic [8:0] O_MEAN = 9'b100000001;
  localparam logic [8:0] O_WAIT = 9'b000000001;
  localparam logic [8:0] O_SS   = 9'b011000001;
  localparam logic [8:0] O_B1   = 9'b000100001;
  localparam logic [8:0] O_B0   = 9'b000010001;
  localparam logic [8:0] O_ERR  = 9'b000001101;
  localparam logic [8:0] O_DONE = 9'b000000011;

  typedef struct {
    logic       rst;
    logic       st;
    logic       md;
    logic [7:0] adrr;
    logic [8:0] outs;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start_bus;
  logic [2:0] md_bus;
  logic [7:0] adrr0, adrr1, adrr2;
  logic [2:0] en1_w, ld_p_w, ld_ss_w, ld_b1_w, ld_b0_w, en2_w, ld_er_w, ready_w, busy_w;
  int         n_checks = 0;
  int         n_fail = 0;
  logic       monitor_on = 1'b0;
  vec_t       vecs[21];

  always #5 clk = ~clk;

  regression_sequencer #(.N_SAMPLES(4), .ADDR_W(8)) dut4 (
    .clk(clk), .reset(reset), .start(start_bus[0]), .mean_done(md_bus[0]), .adrr(adrr0),
    .en1(en1_w[0]), .ld_p(ld_p_w[0]), .ld_ss(ld_ss_w[0]), .ld_B1(ld_b1_w[0]), .ld_B0(ld_b0_w[0]),
    .en2(en2_w[0]), .ld_er(ld_er_w[0]), .Ready(ready_w[0]), .busy(busy_w[0])
  );

  regression_sequencer #(.N_SAMPLES(1), .ADDR_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start_bus[1]), .mean_done(md_bus[1]), .adrr(adrr1),
    .en1(en1_w[1]), .ld_p(ld_p_w[1]), .ld_ss(ld_ss_w[1]), .ld_B1(ld_b1_w[1]), .ld_B0(ld_b0_w[1]),
    .en2(en2_w[1]), .ld_er(ld_er_w[1]), .Ready(ready_w[1]), .busy(busy_w[1])
  );

  regression_sequencer #(.N_SAMPLES(256), .ADDR_W(8)) dut256 (
    .clk(clk), .reset(reset), .start(start_bus[2]), .mean_done(md_bus[2]), .adrr(adrr2),
    .en1(en1_w[2]), .ld_p(ld_p_w[2]), .ld_ss(ld_ss_w[2]), .ld_B1(ld_b1_w[2]), .ld_B0(ld_b0_w[2]),
    .en2(en2_w[2]), .ld_er(ld_er_w[2]), .Ready(ready_w[2]), .busy(busy_w[2])
  );

  function automatic void check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  function automatic logic [8:0] outs_of(input int k);
    return {en1_w[k], ld_p_w[k], ld_ss_w[k], ld_b1_w[k], ld_b0_w[k],
            en2_w[k], ld_er_w[k], ready_w[k], busy_w[k]};
  endfunction

  function automatic logic [5:0] strobes_of(input int k);
    return {en1_w[k], ld_p_w[k], ld_b1_w[k], ld_b0_w[k], en2_w[k], ready_w[k]};
  endfunction

  function automatic logic [7:0] adrr_of(input int k);
    case (k)
      0:       return adrr0;
      1:       return adrr1;
      default: return adrr2;
    endcase
  endfunction

  // The phase strobes of every instance must be mutually exclusive at all times.
  always @(negedge clk) begin
    if (monitor_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("one_hot_dut%0d", k), 32'($countones(strobes_of(k)) <= 1), 32'd1);
      end
    end
  end

  // Drives one run on instance k and checks every sweep cycle against a bench-side counter.
  // md_mode 0: mean_done during WAIT_MEAN cycle md_at; md_mode 1: during MEAN at adrr md_at.
  task automatic run_check(input int k, input int n, input int md_mode, input int md_at,
                           output int ready_cyc, output int w);
    int         i1, i2, i3, nb1, nb0;
    logic [8:0] o;
    logic [7:0] a;
    bit         done;
    i1 = 0; i2 = 0; i3 = 0; nb1 = 0; nb0 = 0;
    w = 0; ready_cyc = 0; done = 0;
    start_bus[k] = 1'b1;
    @(posedge clk); #1;
    start_bus[k] = 1'b0;
    for (int c = 2; c < 1000 && !done; c++) begin
      o = outs_of(k);
      a = adrr_of(k);
      md_bus[k] = (md_mode == 1 && o[8] && a == 8'(md_at)) ||
                  (md_mode == 0 && o == O_WAIT && w + 1 == md_at);
      if (o[8]) begin check("mean_state", o, O_MEAN); check("mean_adrr", a, i1); i1++; end
      if (o == O_WAIT) begin check("wait_adrr", a, 0); w++; end
      if (o[7]) begin check("ss_state", o, O_SS); check("ss_adrr", a, i2); i2++; end
      if (o[5]) begin check("b1_state", o, O_B1); nb1++; end
      if (o[4]) begin check("b0_state", o, O_B0); nb0++; end
      if (o[3]) begin check("err_state", o, O_ERR); check("err_adrr", a, i3); i3++; end
      if (o[1]) begin check("done_state", o, O_DONE); ready_cyc = c; done = 1; end
      @(posedge clk); #1;
    end
    md_bus[k] = 1'b0;
    check("run_completed", done, 1);
    check("mean_len", i1, n);
    check("ss_len", i2, n);
    check("err_len", i3, n);
    check("b1_pulses", nb1, 1);
    check("b0_pulses", nb0, 1);
    check("latency", ready_cyc, run_latency(n, w));
    check("idle_after_done", outs_of(k), O_IDLE);
  endtask

  initial begin
    int         rc, w, n_err;
    bit         found;
    logic [8:0] o;

    reset = 1'b0;
    start_bus = '0;
    md_bus = '0;

    // Nominal N=4 run, one row per cycle: inputs in the cycle, outputs after the edge.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd0, O_IDLE};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd0, O_IDLE};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'd0, O_MEAN};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd1, O_MEAN};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'd2, O_MEAN};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd3, O_MEAN};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd0, O_WAIT};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd0, O_WAIT};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'd0, O_SS};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd1, O_SS};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'd2, O_SS};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd3, O_SS};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd0, O_B1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'd0, O_B0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'd0, O_ERR};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'd1, O_ERR};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'd2, O_ERR};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'd3, O_ERR};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'd0, O_DONE};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 8'd0, O_IDLE};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 8'd0, O_IDLE};

    repeat (2) @(posedge clk);
    #1;
    monitor_on = 1'b1;

    for (int i = 0; i < 21; i++) begin
      reset        = vecs[i].rst;
      start_bus[0] = vecs[i].st;
      md_bus[0]    = vecs[i].md;
      @(posedge clk); #1;
      check($sformatf("vec%0d_adrr", i), adrr0, vecs[i].adrr);
      check($sformatf("vec%0d_outs", i), outs_of(0), vecs[i].outs);
    end
    reset = 1'b1;
    start_bus[0] = 1'b0;
    md_bus[0] = 1'b0;

    // Early mean_done during MEAN at adrr=1: one WAIT_MEAN cycle, Ready in cycle 17.
    run_check(0, 4, 1, 1, rc, w);
    check("early_wait_cycles", w, 1);
    check("early_ready_cycle", rc, 17);

    // Nominal again through the task: mean_done in the 2nd WAIT_MEAN cycle, Ready in cycle 18.
    run_check(0, 4, 0, 2, rc, w);
    check("nominal_wait_cycles", w, 2);
    check("nominal_ready_cycle", rc, 18);

    // Reset in the middle of the SS sweep at adrr=2.
    start_bus[0] = 1'b1;
    @(posedge clk); #1;
    start_bus[0] = 1'b0;
    md_bus[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (ld_p_w[0] && adrr0 == 8'd2) found = 1;
      else begin @(posedge clk); #1; end
    end
    md_bus[0] = 1'b0;
    check("reached_ss_adrr2", found, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("rst_mid_ss_outs", outs_of(0), O_IDLE);
    check("rst_mid_ss_adrr", adrr0, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_mid_ss_quiet", outs_of(0), O_IDLE);
    end
    run_check(0, 4, 0, 2, rc, w);
    check("after_rst_ready_cycle", rc, 18);

    // start raised during ERR and held: ignored until IDLE, then relaunches.
    start_bus[0] = 1'b1;
    @(posedge clk); #1;
    start_bus[0] = 1'b0;
    md_bus[0] = 1'b1;
    n_err = 0;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      o = outs_of(0);
      if (o[3]) begin start_bus[0] = 1'b1; n_err++; end
      if (o[1]) found = 1;
      else begin @(posedge clk); #1; end
    end
    check("err_len_start_held", n_err, 4);
    check("done_with_start_held", found, 1);
    @(posedge clk); #1;
    check("idle_after_done_start_held", outs_of(0), O_IDLE);
    @(posedge clk); #1;
    check("second_run_mean", outs_of(0), O_MEAN);
    check("second_run_adrr", adrr0, 0);
    start_bus[0] = 1'b0;
    found = 0;
    rc = 0;
    for (int c = 2; c < 60 && !found; c++) begin
      if (ready_w[0]) begin found = 1; rc = c; end
      else begin @(posedge clk); #1; end
    end
    md_bus[0] = 1'b0;
    check("second_run_done", found, 1);
    check("second_run_ready_cycle", rc, 17);
    @(posedge clk); #1;

    // Boundary pass lengths: N=1 and N=256.
    run_check(1, 1, 0, 1, rc, w);
    check("n1_ready_cycle", rc, 8);
    run_check(2, 256, 0, 1, rc, w);
    check("n256_ready_cycle", rc, 773);

    monitor_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regression_sequencer.md
REGRESSION_SEQUENCER -- requirements
Module: regression_sequencer

Interface
REQ-001 Parameter N_SAMPLES, default 150: samples per pass; legal range 1..256.
REQ-002 Parameter ADDR_W, default 8: sample address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 start  input  1  run request, sampled in IDLE only.
REQ-006 mean_done  input  1  coefficient calculator reports means valid.
REQ-007 adrr  output  ADDR_W  sample address to the data loader.
REQ-008 en1  output  1  accumulate-means enable to the coefficient calculator.
REQ-009 ld_p, ld_ss  output  1 each  load product-sum and square-sum registers.
REQ-010 ld_B1, ld_B0  output  1 each  load slope and intercept registers.
REQ-011 en2, ld_er  output  1 each  error-checker enable and error-register load.
REQ-012 Ready  output  1  one-cycle run-complete pulse.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, MEAN, WAIT_MEAN, SS, CALC_B1, CALC_B0, ERR, DONE.
REQ-015 IDLE: all outputs 0; start=1 moves to MEAN with adrr=0 on the next cycle.
REQ-016 MEAN: en1=1; adrr steps 0..N_SAMPLES-1, one address per cycle; after adrr=N_SAMPLES-1, go to WAIT_MEAN.
REQ-017 mean_done uses a sticky flag: cleared on MEAN entry, set by mean_done=1 in MEAN or WAIT_MEAN, so an early pulse is not lost.
REQ-018 WAIT_MEAN: all enables 0; adrr=0; stays until the sticky flag or mean_done is 1, then goes to SS; no timeout.
REQ-019 SS: ld_p=ld_ss=1; adrr steps 0..N_SAMPLES-1; then CALC_B1.
REQ-020 CALC_B1: ld_B1=1 for exactly one cycle; then CALC_B0.
REQ-021 CALC_B0: ld_B0=1 for exactly one cycle; then ERR.
REQ-022 ERR: en2=ld_er=1; adrr steps 0..N_SAMPLES-1; then DONE.
REQ-023 DONE: Ready=1 for one cycle; then IDLE.
REQ-024 Only the listed outputs of the current state are 1; all others are 0; all outputs are registered.
REQ-025 The address counter wraps to 0 at each sweep end; with N_SAMPLES=256 it covers 0..255 and does not overflow into an extra cycle.
REQ-026 With N_SAMPLES=1, each sweep lasts exactly one cycle at adrr=0.
REQ-027 start outside IDLE is ignored; start held high through DONE launches a new run the cycle after returning to IDLE.
REQ-028 Latency from the start-sampled edge to the Ready cycle = 3*N_SAMPLES + W + 4 cycles, where W is the number of WAIT_MEAN cycles (W>=1).

Reset
REQ-029 reset=0 at any edge, including mid-sweep, forces IDLE, adrr=0, sticky flag 0 and all outputs 0 by the next cycle.
REQ-030 reset has priority over start and mean_done in the same cycle.

Structure
REQ-031 Package regression_pkg holds the state enumeration, the N_SAMPLES and ADDR_W defaults, and the pass-length constant.
REQ-032 One sub-module, sample_addr_counter (clear, enable, terminal-count flag), is shared by the three sweeps.

Verification (N_SAMPLES=4 unless noted)
REQ-033 Nominal run: start pulse, mean_done at 2nd WAIT_MEAN cycle -> en1 at adrr 0,1,2,3; ld_p/ld_ss at 0..3; single ld_B1, then single ld_B0; en2/ld_er at 0..3; Ready pulse 18 cycles after start edge.
REQ-034 Early mean_done: pulse during MEAN at adrr=1 -> WAIT_MEAN lasts 1 cycle, Ready at cycle 17.
REQ-035 Reset mid-SS at adrr=2 -> next cycle IDLE, adrr=0, busy=0, no Ready; a fresh start then completes normally.
REQ-036 start asserted during ERR and held -> ignored until IDLE; second run begins one cycle after the DONE cycle.
REQ-037 N_SAMPLES=1 and N_SAMPLES=256 -> sweep lengths of 1 and 256 cycles; adrr reaches 255 with no wrap glitch.
REQ-038 Throughout all runs the bench checks that at most one of {en1, ld_p, ld_B1, ld_B0, en2, Ready} is high per cycle.
